// File: rtl/watch_pkg.sv
// Shared definitions for the watch alarm path: state encoding, BCD digit limits, helpers.
// No timing or backpressure of its own; constants and a pure function only.
package watch_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EDIT    = 3'd1;
  localparam logic [2:0] ST_ARMED   = 3'd2;
  localparam logic [2:0] ST_RINGING = 3'd3;
  localparam logic [2:0] ST_SNOOZE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    EDIT    = ST_EDIT,
    ARMED   = ST_ARMED,
    RINGING = ST_RINGING,
    SNOOZE  = ST_SNOOZE
  } alarmState_t;

  localparam logic [3:0] H1_MAX       = 4'd2;
  localparam logic [3:0] H0_MAX       = 4'd9;
  localparam logic [3:0] H0_MAX_AT_20 = 4'd3;
  localparam logic [3:0] M1_MAX       = 4'd5;
  localparam logic [3:0] M0_MAX       = 4'd9;

  localparam logic [1:0] DIG_H1 = 2'd0;
  localparam logic [1:0] DIG_H0 = 2'd1;
  localparam logic [1:0] DIG_M1 = 2'd2;
  localparam logic [1:0] DIG_M0 = 2'd3;

  function automatic logic [3:0] satInc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/alarm_bcd_inc.sv
// Next value of one BCD alarm digit with wrap; hour-units limit drops to 3 in the 20s.
// Purely combinational, no backpressure.
module alarm_bcd_inc
  import watch_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [1:0] digitIdx,
  input  logic [3:0] hour1,
  output logic [3:0] nextDigit
);

  logic [3:0] limit;

  always_comb begin
    limit = M0_MAX;
    case (digitIdx)
      DIG_H1:  limit = H1_MAX;
      DIG_H0:  limit = (hour1 == H1_MAX) ? H0_MAX_AT_20 : H0_MAX;
      DIG_M1:  limit = M1_MAX;
      default: limit = M0_MAX;
    endcase
    nextDigit = (digit >= limit) ? 4'd0 : digit + 4'd1;
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencer: edit/arm/ring/snooze/timeout; every output registered, one-cycle latency.
// No backpressure: button and minute pulses are consumed in the cycle they arrive.
module alarm_controller
  import watch_pkg::*;
#(
  parameter int RING_MINUTES   = 1,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       minTick,
  input  logic [3:0] curHour1,
  input  logic [3:0] curHour0,
  input  logic [3:0] curMin1,
  input  logic [3:0] curMin0,
  input  logic       btnMode,
  input  logic       btnNext,
  input  logic       btnUp,
  input  logic       btnAck,
  input  logic       btnSnooze,
  output logic       alarm,
  output logic       armed,
  output logic       editing,
  output logic [1:0] cursor,
  output logic [3:0] savHour1,
  output logic [3:0] savHour0,
  output logic [3:0] savMin1,
  output logic [3:0] savMin0
);

  localparam logic [3:0] RING_LIM   = 4'(RING_MINUTES);
  localparam logic [3:0] SNOOZE_LIM = 4'(SNOOZE_MINUTES);

  alarmState_t state, stateNext;
  logic [3:0]  ringCnt, ringNext, ringInc;
  logic [3:0]  snzCnt, snzNext, snzInc;
  logic [1:0]  cursorNext;
  logic [3:0]  h1Next, h0Next, m1Next, m0Next;
  logic [3:0]  selDigit, incDigit;
  logic        timeMatch;

  always_comb begin
    case (cursor)
      DIG_H1:  selDigit = savHour1;
      DIG_H0:  selDigit = savHour0;
      DIG_M1:  selDigit = savMin1;
      default: selDigit = savMin0;
    endcase
  end

  alarm_bcd_inc uInc (
    .digit    (selDigit),
    .digitIdx (cursor),
    .hour1    (savHour1),
    .nextDigit(incDigit)
  );

  assign timeMatch = (savHour1 == curHour1) && (savHour0 == curHour0) &&
                     (savMin1 == curMin1) && (savMin0 == curMin0);
  assign ringInc   = satInc(ringCnt);
  assign snzInc    = satInc(snzCnt);

  always_comb begin
    stateNext  = state;
    ringNext   = ringCnt;
    snzNext    = snzCnt;
    cursorNext = cursor;
    h1Next     = savHour1;
    h0Next     = savHour0;
    m1Next     = savMin1;
    m0Next     = savMin0;
    case (state)
      IDLE: begin
        if (btnMode) begin
          stateNext  = EDIT;
          cursorNext = DIG_H1;
        end
      end
      EDIT: begin
        if (btnMode) begin
          stateNext = ARMED;
        end else if (btnNext) begin
          cursorNext = cursor + 2'd1;
        end else if (btnUp) begin
          case (cursor)
            DIG_H1: begin
              h1Next = incDigit;
              // Entering the 20s must never leave an illegal hour like 27.
              if (incDigit == H1_MAX && savHour0 > H0_MAX_AT_20) h0Next = H0_MAX_AT_20;
            end
            DIG_H0:  h0Next = incDigit;
            DIG_M1:  m1Next = incDigit;
            default: m0Next = incDigit;
          endcase
        end
      end
      ARMED: begin
        if (btnMode) begin
          stateNext = IDLE;
        end else if (minTick && timeMatch) begin
          stateNext = RINGING;
          ringNext  = 4'd0;
        end
      end
      RINGING: begin
        if (btnMode) begin
          stateNext = IDLE;
        end else if (btnAck) begin
          stateNext = ARMED;
        end else if (btnSnooze) begin
          stateNext = SNOOZE;
          snzNext   = 4'd0;
        end else if (minTick) begin
          ringNext = ringInc;
          if (ringInc == RING_LIM) stateNext = ARMED;
        end
      end
      SNOOZE: begin
        if (btnMode) begin
          stateNext = IDLE;
        end else if (btnAck) begin
          stateNext = ARMED;
        end else if (minTick) begin
          snzNext = snzInc;
          if (snzInc == SNOOZE_LIM) begin
            stateNext = RINGING;
            ringNext  = 4'd0;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they settle with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ringCnt  <= 4'd0;
      snzCnt   <= 4'd0;
      cursor   <= 2'd0;
      savHour1 <= 4'd0;
      savHour0 <= 4'd0;
      savMin1  <= 4'd0;
      savMin0  <= 4'd0;
      alarm    <= 1'b0;
      armed    <= 1'b0;
      editing  <= 1'b0;
    end else begin
      state    <= stateNext;
      ringCnt  <= ringNext;
      snzCnt   <= snzNext;
      cursor   <= cursorNext;
      savHour1 <= h1Next;
      savHour0 <= h0Next;
      savMin1  <= m1Next;
      savMin0  <= m0Next;
      alarm    <= (stateNext == RINGING);
      armed    <= (stateNext == ARMED) || (stateNext == RINGING) || (stateNext == SNOOZE);
      editing  <= (stateNext == EDIT);
    end
  end

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequencing controller for the watch's alarm function. It owns the stored alarm time and its BCD edit cursor, arms and disarms the alarm, and compares stored against current time once per minute. It drives the buzzer through ring, snooze and auto-timeout phases. It sits between the button debouncer/one-shot stage and the display/buzzer outputs, next to the timekeeping counter that supplies the current BCD time.

## Interface
- RING_MINUTES, default 1: minute ticks the buzzer sounds before auto-silencing (1..15).
- SNOOZE_MINUTES, default 5: minute ticks spent in snooze before re-ringing (1..15).
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- minTick  in  1  one-cycle pulse on the cycle the current time enters a new minute
- curHour1, curHour0, curMin1, curMin0  in  4 each  current time, BCD, 24 h
- btnMode  in  1  one-cycle pulse; cycles IDLE/EDIT/ARMED; disarms from any ringing state
- btnNext  in  1  one-cycle pulse; advances edit cursor
- btnUp  in  1  one-cycle pulse; increments digit under cursor
- btnAck  in  1  one-cycle pulse; silences ring/snooze, stays armed
- btnSnooze  in  1  one-cycle pulse; ring -> snooze
- alarm  out  1  buzzer drive
- armed  out  1  high in ARMED, RINGING, SNOOZE
- editing  out  1  high in EDIT
- cursor  out  2  digit under edit: 0=H1, 1=H0, 2=M1, 3=M0
- savHour1, savHour0, savMin1, savMin0  out  4 each  stored alarm time, BCD

## Operation
- States: IDLE, EDIT, ARMED, RINGING, SNOOZE.
- IDLE: btnMode -> EDIT with cursor=0. The stored time is kept, not reloaded.
- EDIT:
  - btnMode -> ARMED (commits).
  - btnNext -> cursor+1 mod 4.
  - btnUp -> increment the selected digit with wrap. Limits: H1 0..2; H0 0..9, or 0..3 when H1=2; M1 0..5; M0 0..9.
  - If H1 becomes 2 while H0>3, H0 is forced to 3 in the same cycle.
  - minTick is ignored.
- ARMED:
  - btnMode -> IDLE.
  - minTick with all four sav digits equal to the cur digits -> RINGING, ring counter cleared.
- RINGING: alarm=1.
  - btnMode -> IDLE.
  - btnAck -> ARMED.
  - btnSnooze -> SNOOZE, snooze counter cleared.
  - Each minTick increments the ring counter. When it reaches RING_MINUTES -> ARMED.
- SNOOZE: alarm=0.
  - btnMode -> IDLE.
  - btnAck -> ARMED.
  - Each minTick increments the snooze counter. When it reaches SNOOZE_MINUTES -> RINGING, ring counter cleared.
- Same-cycle priority: btnMode > btnAck > btnSnooze > minTick. In EDIT: btnMode > btnNext > btnUp.
- A match is evaluated only on minTick cycles. A cur-time change without minTick never rings.
- After returning to ARMED, the same minute does not re-trigger, because the next minTick carries a different time.

## Timing
- All outputs are registered. An input event sampled at edge N is visible after edge N (one-cycle latency). No combinational path from inputs to outputs.
- The alarm rises on the cycle after the matching minTick and falls on the cycle after btnAck, btnSnooze, btnMode or the timeout tick.
- Reset values: state IDLE; alarm 0, armed 0, editing 0, cursor 0; sav digits 0,0,0,0; both counters 0.
- Reset mid-ring silences the buzzer at the next edge and clears the stored time.
- Counters are 4 bits wide and saturate. The timeout compares with equality at the moment of the increment.

## Structure
- Shared package watch_pkg holds:
  - the state encoding (3-bit localparams);
  - the digit limits: H1_MAX=2, H0_MAX=9, H0_MAX_AT_20=3, M1_MAX=5, M0_MAX=9.
- One sub-module, alarm_bcd_inc. It is combinational: it takes the digit value, the digit index and the current H1, and returns the next value with wrap and the H1=2 clamp. The controller instantiates it once, on the digit selected by the cursor.
- The FSM, counters and sav registers live in alarm_controller.

## Test plan
- Edit and wrap: from IDLE, btnMode, then btnUp ×3 on H1 -> H1 sequence 1,2,0. Set H1=2 with H0=7 -> H0 becomes 3 on the same edge.
- Match: set the alarm to 07:30 and arm. Drive cur=07:30 with minTick -> alarm=1 on the next cycle. Cur=07:30 without minTick -> alarm stays 0.
- Snooze: ringing, then btnSnooze -> alarm 0. After SNOOZE_MINUTES=5 minTicks, alarm=1 on the cycle after the 5th.
- Timeout: RING_MINUTES=1, ringing, one minTick -> ARMED, alarm 0, armed 1. The following minTick at 07:31 does not ring.
- Priority: btnMode and btnAck in the same cycle while RINGING -> IDLE, armed 0. btnAck and a matching minTick in ARMED -> RINGING.
- Reset: assert reset while RINGING -> next cycle alarm 0, state IDLE, sav 0000, cursor 0.
